// File: rtl/calc_seq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : calc_seq_arbiter
// Brief    : Two-port round-robin sequencer that issues commands to the
//            combinational signed_cal calculator and returns the captured
//            result. The optional build macro CALC_DIV0_CHECK_EN short-cuts
//            divide-by-zero commands to an error response.
// Revision : 1.0 - initial release
// ============================================================================
module calc_seq_arbiter #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [16:0] req0_cmd,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [16:0] req1_cmd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [9:0]  resp_op,
  output logic [3:0]  resp_aux,
  output logic        resp_err,
  output logic        calc_en,
  output logic [2:0]  calc_mode,
  output logic [3:0]  calc_a,
  output logic [3:0]  calc_b,
  output logic [1:0]  calc_sign,
  output logic [1:0]  calc_shift_value,
  output logic        calc_shift_number,
  output logic        calc_rorl,
  input  logic [9:0]  calc_op,
  input  logic [3:0]  calc_rem,
  input  logic [3:0]  calc_shift,
  input  logic [2:0]  calc_hel,
  input  logic        calc_and,
  input  logic        calc_or
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] C_CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic [16:0] cmd_q, cmd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        id_q, id_d;
  logic [9:0]  op_q, op_d;
  logic [3:0]  aux_q, aux_d;

  logic        any_valid;
  logic        win_id;
  logic [16:0] win_cmd;
  logic        accept;
  logic [3:0]  capt_aux;

  // Both valid: the pointer decides; otherwise the lone valid requester wins.
  always_comb begin
    any_valid  = req0_valid | req1_valid;
    win_id     = (req0_valid & req1_valid) ? ptr_q : req1_valid;
    win_cmd    = win_id ? req1_cmd : req0_cmd;
    req0_ready = (state_q == IDLE) & ~rst & any_valid & ~win_id;
    req1_ready = (state_q == IDLE) & ~rst & any_valid & win_id;
    accept     = req0_ready | req1_ready;
  end

  always_comb begin
    capt_aux = 4'd0;
    case (cmd_q[16:14])
      3'b011:  capt_aux = calc_rem;
      3'b100:  capt_aux = {1'b0, calc_hel};
      3'b101:  capt_aux = {3'b000, calc_and};
      3'b110:  capt_aux = {3'b000, calc_or};
      3'b111:  capt_aux = calc_shift;
      default: capt_aux = 4'd0;
    endcase
  end

`ifdef CALC_DIV0_CHECK_EN
  logic err_q, err_d;
  logic win_div0;

  always_comb begin
    win_div0 = (win_cmd[16:14] == 3'b011) && (win_cmd[9:6] == 4'd0);
  end

  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    op_d    = op_q;
    aux_d   = aux_q;
`ifdef CALC_DIV0_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          cmd_d   = win_cmd;
          id_d    = win_id;
          ptr_d   = ~win_id;
          cnt_d   = C_CNT_LOAD;
          state_d = RUN;
`ifdef CALC_DIV0_CHECK_EN
          err_d   = 1'b0;
          // Division by zero never reaches the calculator.
          if (win_div0) begin
            state_d = RESP;
            op_d    = 10'd0;
            aux_d   = 4'd0;
            err_d   = 1'b1;
          end
`endif
        end
      end
      RUN: begin
        if (cnt_q == 4'd0) begin
          op_d    = calc_op;
          aux_d   = capt_aux;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      cmd_q   <= 17'd0;
      cnt_q   <= 4'd0;
      id_q    <= 1'b0;
      op_q    <= 10'd0;
      aux_q   <= 4'd0;
`ifdef CALC_DIV0_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      op_q    <= op_d;
      aux_q   <= aux_d;
`ifdef CALC_DIV0_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign resp_valid        = (state_q == RESP);
  assign resp_id           = id_q;
  assign resp_op           = op_q;
  assign resp_aux          = aux_q;
  assign calc_en           = (state_q == RUN);
  assign calc_mode         = cmd_q[16:14];
  assign calc_a            = cmd_q[13:10];
  assign calc_b            = cmd_q[9:6];
  assign calc_sign         = cmd_q[5:4];
  assign calc_shift_value  = cmd_q[3:2];
  assign calc_shift_number = cmd_q[1];
  assign calc_rorl         = cmd_q[0];

endmodule
`default_nettype wire

// File: tb/tb_calc_seq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_seq_arbiter
// Brief    : Self-checking bench for calc_seq_arbiter with a behavioural
//            calculator and a cycle-indexed transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_seq_arbiter;

  localparam int C_SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, resp_ready;
  logic [16:0] req0_cmd, req1_cmd;
  logic        req0_ready, req1_ready, resp_valid, resp_id, resp_err, calc_en;
  logic [9:0]  resp_op, calc_op;
  logic [3:0]  resp_aux, calc_a, calc_b, calc_rem, calc_shift;
  logic [2:0]  calc_mode, calc_hel;
  logic [1:0]  calc_sign, calc_shift_value;
  logic        calc_shift_number, calc_rorl, calc_and, calc_or;
  logic [22:0] calc_res;

  always #5 clk = ~clk;

  calc_seq_arbiter #(.SETTLE_CYCLES(C_SETTLE)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_op(resp_op), .resp_aux(resp_aux), .resp_err(resp_err),
    .calc_en(calc_en), .calc_mode(calc_mode), .calc_a(calc_a), .calc_b(calc_b),
    .calc_sign(calc_sign), .calc_shift_value(calc_shift_value),
    .calc_shift_number(calc_shift_number), .calc_rorl(calc_rorl),
    .calc_op(calc_op), .calc_rem(calc_rem), .calc_shift(calc_shift),
    .calc_hel(calc_hel), .calc_and(calc_and), .calc_or(calc_or)
  );

  // Behavioural calculator: returns {op, rem, shift, hel, and, or}.
  function automatic logic [22:0] calc_fn(input logic [16:0] k);
    logic [3:0] a, b, src, sh, rem;
    logic [9:0] op;
    logic [7:0] tmp;
    int sa, sb;
    a   = k[13:10];
    b   = k[9:6];
    sa  = k[5] ? -int'(a) : int'(a);
    sb  = k[4] ? -int'(b) : int'(b);
    rem = 4'd0;
    case (k[16:14])
      3'd0: op = 10'(sa + sb);
      3'd1: op = 10'(sa - sb);
      3'd2: op = 10'(sa * sb);
      3'd3: begin
        if (b == 4'd0) begin
          op  = 10'h3FF;
          rem = a;
        end else begin
          op  = 10'(sa / sb);
          rem = a % b;
        end
      end
      default: op = {2'b00, a, b};
    endcase
    src = k[1] ? b : a;
    if (k[0]) begin
      tmp = {src, src} << k[3:2];
      sh  = tmp[7:4];
    end else begin
      tmp = {src, src} >> k[3:2];
      sh  = tmp[3:0];
    end
    return {op, rem, sh, {a > b, a == b, a < b}, |(a & b), |(a | b)};
  endfunction

  function automatic logic [3:0] aux_of(input logic [2:0] md, input logic [22:0] r);
    case (md)
      3'd3:    return r[12:9];
      3'd4:    return {1'b0, r[4:2]};
      3'd5:    return {3'b000, r[1]};
      3'd6:    return {3'b000, r[0]};
      3'd7:    return r[8:5];
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [16:0] mk(input int md, input int a, input int b, input int sg);
    return {3'(md), 4'(a), 4'(b), 2'(sg), 4'b0000};
  endfunction

  always_comb calc_res = calc_fn({calc_mode, calc_a, calc_b, calc_sign,
                                  calc_shift_value, calc_shift_number, calc_rorl});
  assign calc_op    = calc_res[22:13];
  assign calc_rem   = calc_res[12:9];
  assign calc_shift = calc_res[8:5];
  assign calc_hel   = calc_res[4:2];
  assign calc_and   = calc_res[1];
  assign calc_or    = calc_res[0];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: cycle index k is the interval following rising edge k.
  int          cyc;
  bit          m_busy;
  int          m_resp_cyc;
  bit          m_ptr;
  logic [16:0] m_cmd;
  bit          m_id, m_err;
  logic [9:0]  m_op;
  logic [3:0]  m_aux;
  int          acc_cyc, lat;
  bit          lat_pend;
  bit          grants[$];
  logic [9:0]  obs_op;
  logic [3:0]  obs_aux;
  logic        obs_id, obs_err;
  int          obs_cnt;

  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_cmd = '0; lat_pend = 0;
  endtask

  task automatic step(input bit v0, input logic [16:0] k0, input bit v1,
                      input logic [16:0] k1, input bit rdy);
    bit idle, win, vis;
    logic [22:0] r;
    @(negedge clk);
    req0_valid = v0; req0_cmd = k0; req1_valid = v1; req1_cmd = k1; resp_ready = rdy;
    #1;
    idle = !m_busy;
    win  = (v0 && v1) ? m_ptr : v1;
    vis  = m_busy && (cyc >= m_resp_cyc);
    check("req0_ready", 32'(req0_ready), 32'(idle && (v0 || v1) && !win));
    check("req1_ready", 32'(req1_ready), 32'(idle && (v0 || v1) && win));
    check("calc_en", 32'(calc_en), 32'(m_busy && (cyc < m_resp_cyc)));
    check("resp_valid", 32'(resp_valid), 32'(vis));
    check("calc_pins", 32'({calc_mode, calc_a, calc_b, calc_sign, calc_shift_value,
                            calc_shift_number, calc_rorl}), 32'(m_cmd));
    if (vis) begin
      check("resp_id", 32'(resp_id), 32'(m_id));
      check("resp_op", 32'(resp_op), 32'(m_op));
      check("resp_aux", 32'(resp_aux), 32'(m_aux));
      check("resp_err", 32'(resp_err), 32'(m_err));
    end
    if (resp_valid && lat_pend) begin
      lat = cyc - acc_cyc;
      lat_pend = 0;
    end
    if (resp_valid && rdy) begin
      obs_op = resp_op; obs_aux = resp_aux; obs_id = resp_id; obs_err = resp_err;
      obs_cnt++;
    end
    @(posedge clk);
    cyc++;
    if (idle && (v0 || v1)) begin
      m_cmd = win ? k1 : k0;
      m_id  = win;
      m_ptr = !win;
      r     = calc_fn(m_cmd);
      m_op  = r[22:13];
      m_aux = aux_of(m_cmd[16:14], r);
      m_err = 0;
      m_resp_cyc = cyc + C_SETTLE;
`ifdef CALC_DIV0_CHECK_EN
      if (m_cmd[16:14] == 3'd3 && m_cmd[9:6] == 4'd0) begin
        m_resp_cyc = cyc; m_op = '0; m_aux = '0; m_err = 1;
      end
`endif
      m_busy = 1;
      acc_cyc = cyc; lat_pend = 1;
      grants.push_back(win);
    end else if (vis && rdy) begin
      m_busy = 0;
    end
  endtask

  task automatic idle_cycles(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, '0, 0, '0, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; req0_valid = 0; req1_valid = 0; resp_ready = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
    check("rst_outputs", 32'({req0_ready, req1_ready, resp_valid, resp_id, resp_op,
                              resp_aux, resp_err, calc_en}), 32'd0);
    check("rst_calc_pins", 32'({calc_mode, calc_a, calc_b, calc_sign, calc_shift_value,
                                calc_shift_number, calc_rorl}), 32'd0);
  endtask

  initial begin
    bit alt_ok, lone_ok;
    logic [16:0] k0, k1;
    rst = 1; req0_valid = 0; req1_valid = 0; resp_ready = 0;
    req0_cmd = '0; req1_cmd = '0;
    cyc = 0; obs_cnt = 0; lat = 0; acc_cyc = 0;
    repeat (2) @(posedge clk);
    do_reset();

    // Add on requester 0
    step(1, mk(0, 3, 2, 0), 0, '0, 1);
    idle_cycles(C_SETTLE + 2, 1);
    check("add_latency", 32'(lat), 32'(C_SETTLE));
    check("add_op", 32'(obs_op), 32'h005);
    check("add_id", 32'(obs_id), 32'd0);
    check("add_aux", 32'(obs_aux), 32'd0);

    // Signed subtract and multiply on requester 1
    step(0, '0, 1, mk(1, 2, 5, 0), 1);
    idle_cycles(C_SETTLE + 2, 1);
    check("sub_op", 32'(obs_op), 32'h3FD);
    check("sub_id", 32'(obs_id), 32'd1);
    step(0, '0, 1, mk(2, 3, 2, 1), 1);
    idle_cycles(C_SETTLE + 2, 1);
    check("mul_op", 32'(obs_op), 32'h3FA);

    // Divide, then divide by zero
    step(1, mk(3, 7, 2, 0), 0, '0, 1);
    idle_cycles(C_SETTLE + 2, 1);
    check("div_op", 32'(obs_op), 32'h003);
    check("div_aux", 32'(obs_aux), 32'h1);
    step(1, mk(3, 9, 0, 0), 0, '0, 1);
`ifdef CALC_DIV0_CHECK_EN
    check("div0_latency", 32'(lat), 32'd0);
`endif
    idle_cycles(C_SETTLE + 2, 1);
`ifdef CALC_DIV0_CHECK_EN
    check("div0_err", 32'(obs_err), 32'd1);
    check("div0_op", 32'(obs_op), 32'd0);
`else
    check("div0_err", 32'(obs_err), 32'd0);
`endif

    // Arbitration: both valid continuously
    grants.delete();
    for (int i = 0; i < 6 * (C_SETTLE + 2); i++)
      step(1, mk(0, i % 16, 1, 0), 1, mk(1, 5, i % 16, 0), 1);
    alt_ok = (grants.size() >= 5);
    for (int i = 1; i < grants.size(); i++) if (grants[i] == grants[i-1]) alt_ok = 0;
    check("arb_alternate", 32'(alt_ok), 32'd1);
    idle_cycles(C_SETTLE + 2, 1);

    // Lone requester granted back-to-back
    grants.delete();
    for (int i = 0; i < 3 * (C_SETTLE + 2); i++) step(0, '0, 1, mk(2, i % 16, 3, 2), 1);
    lone_ok = (grants.size() == 3);
    foreach (grants[i]) if (grants[i] != 1'b1) lone_ok = 0;
    check("arb_lone_b2b", 32'(lone_ok), 32'd1);
    idle_cycles(C_SETTLE + 2, 1);

    // Backpressure with both requesters waiting
    step(1, mk(4, 6, 9, 0), 0, '0, 0);
    for (int i = 0; i < C_SETTLE + 5; i++) step(1, mk(5, 1, 1, 0), 1, mk(6, 2, 2, 0), 0);
    idle_cycles(C_SETTLE + 2, 1);

    // Reset during RUN
    step(1, mk(0, 4, 4, 0), 0, '0, 1);
    do_reset();
    obs_cnt = 0;
    idle_cycles(C_SETTLE + 3, 1);
    check("rst_no_resp", 32'(obs_cnt), 32'd0);
    grants.delete();
    step(1, mk(0, 1, 1, 0), 1, mk(0, 2, 2, 0), 1);
    check("rst_ptr_zero", 32'(grants.size() == 1 && grants[0] == 1'b0), 32'd1);
    idle_cycles(C_SETTLE + 2, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      k0 = 17'($urandom());
      k1 = 17'($urandom());
      if ($urandom_range(7) == 0) k0[9:6] = 4'd0;
      step($urandom_range(9) < 6, k0, $urandom_range(9) < 5, k1, $urandom_range(3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
